puf_eval_ctrl: RTL

//  Sequencer for the PDL_PUF response array. Accepts a 128-bit challenge over a valid/ready handshake
//  and drives the array's challenge, reset and trigger lines in a fixed timed sequence.

---
 rtl/puf_eval_ctrl_pkg.sv | 25 ++
 rtl/puf_eval_ctrl_if.sv | 25 ++
 rtl/puf_eval_ctrl_resp_sync.sv | 24 ++
 rtl/puf_eval_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/puf_eval_ctrl_pkg.sv
// Shared types and defaults for the PUF evaluation sequencer.
// The PUF_MAJORITY_VOTE_EN macro (used by puf_eval_ctrl) selects multi-evaluation voting.
package puf_eval_ctrl_pkg;

    localparam int CHAL_W_DEF     = 128;
    localparam int RESP_W_DEF     = 6;
    localparam int RST_CYC_DEF    = 4;
    localparam int SETTLE_CYC_DEF = 16;
    localparam int NUM_EVAL_DEF   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_FIRE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    // Width of the shared phase down-counter.
    function automatic int cnt_width(input int rst_cyc, input int settle_cyc);
        return $clog2(((rst_cyc > settle_cyc) ? rst_cyc : settle_cyc) + 1);
    endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Host-side challenge request / response handshake bundle for puf_eval_ctrl.
interface puf_eval_ctrl_if
    import puf_eval_ctrl_pkg::*;
#(
    parameter int CHAL_W = CHAL_W_DEF,
    parameter int RESP_W = RESP_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [CHAL_W-1:0] req_challenge;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RESP_W-1:0] rsp_data;
    logic [RESP_W-1:0] rsp_unstable;

    modport master (
        output req_valid, req_challenge, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_unstable
    );

    modport slave (
        input  req_valid, req_challenge, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_unstable
    );
endinterface

// File: rtl/puf_eval_ctrl_resp_sync.sv
// Two-flop synchroniser for the asynchronous arbiter outputs of the PUF array.
module puf_eval_ctrl_resp_sync #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer driving reset/trigger/challenge of the arbiter PUF array and returning its response.
// Define PUF_MAJORITY_VOTE_EN for NUM_EVAL evaluations per challenge with per-bit majority vote.
//
// state   | meaning
// IDLE    | ready for a challenge, array held in reset
// LOAD    | array reset held high for RST_CYC cycles
// ARM     | reset released, challenge settling
// FIRE    | trigger high for SETTLE_CYC cycles, response synchronising
// CAPTURE | sample synchronised response, loop or finish
// DONE    | first cycle registers result, then response held until accepted
module puf_eval_ctrl
    import puf_eval_ctrl_pkg::*;
#(
    parameter int CHAL_W     = CHAL_W_DEF,
    parameter int RESP_W     = RESP_W_DEF,
    parameter int RST_CYC    = RST_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int NUM_EVAL   = NUM_EVAL_DEF
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    puf_eval_ctrl_if.slave    host,
    output logic              busy_o,
    output logic [CHAL_W-1:0] puf_challenge_o,
    output logic              puf_reset_o,
    output logic              puf_trigger_o,
    input  logic [RESP_W-1:0] puf_response_i
);
    localparam int CNT_W = cnt_width(RST_CYC, SETTLE_CYC);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [RESP_W-1:0]   rsp_data_q, rsp_data_d;
    logic                puf_reset_q, puf_trigger_q;
    logic [RESP_W-1:0]   resp_sync;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int EVAL_W = $clog2(NUM_EVAL + 1);
    logic [EVAL_W-1:0]             eval_q, eval_d;
    logic [RESP_W-1:0][EVAL_W-1:0] ones_q, ones_d;
    logic [RESP_W-1:0]             rsp_unst_q, rsp_unst_d;
`else
    logic [RESP_W-1:0]             cap_q, cap_d;
`endif

    puf_eval_ctrl_resp_sync #(.W(RESP_W)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (reset_n_i),
        .d_i     (puf_response_i),
        .q_o     (resp_sync)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chal_d      = chal_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef PUF_MAJORITY_VOTE_EN
        eval_d      = eval_q;
        ones_d      = ones_q;
        rsp_unst_d  = rsp_unst_q;
`else
        cap_d       = cap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (host.req_valid) begin
                    chal_d  = host.req_challenge;
                    cnt_d   = CNT_W'(RST_CYC - 1);
`ifdef PUF_MAJORITY_VOTE_EN
                    eval_d  = '0;
                    ones_d  = '0;
`endif
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt_q == '0) state_d = ST_ARM;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_ARM: begin
                cnt_d   = CNT_W'(SETTLE_CYC - 1);
                state_d = ST_FIRE;
            end
            ST_FIRE: begin
                if (cnt_q == '0) state_d = ST_CAPTURE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_CAPTURE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                for (int i = 0; i < RESP_W; i++)
                    ones_d[i] = ones_q[i] + EVAL_W'(resp_sync[i]);
                eval_d = eval_q + 1'b1;
                if (eval_q == EVAL_W'(NUM_EVAL - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CNT_W'(RST_CYC - 1);
                    state_d = ST_LOAD;
                end
`else
                cap_d   = resp_sync;
                state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                    for (int i = 0; i < RESP_W; i++) begin
                        rsp_data_d[i] = ones_q[i] > EVAL_W'(NUM_EVAL / 2);
                        rsp_unst_d[i] = (ones_q[i] != '0) && (ones_q[i] != EVAL_W'(NUM_EVAL));
                    end
`else
                    rsp_data_d  = cap_q;
`endif
                end else if (host.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Array controls are registered from the next state so they switch glitch-free with it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            chal_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            puf_reset_q   <= 1'b1;
            puf_trigger_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            chal_q        <= chal_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            puf_reset_q   <= (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DONE);
            puf_trigger_q <= (state_d == ST_FIRE);
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            eval_q     <= '0;
            ones_q     <= '0;
            rsp_unst_q <= '0;
        end else begin
            eval_q     <= eval_d;
            ones_q     <= ones_d;
            rsp_unst_q <= rsp_unst_d;
        end
    end
    assign host.rsp_unstable = rsp_unst_q;
`else
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cap_q <= '0;
        else            cap_q <= cap_d;
    end
    assign host.rsp_unstable = '0;
`endif

    assign host.req_ready   = (state_q == ST_IDLE);
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_data    = rsp_data_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign puf_challenge_o  = chal_q;
    assign puf_reset_o      = puf_reset_q;
    assign puf_trigger_o    = puf_trigger_q;
endmodule
